// File: rtl/trace_pkg.sv
// Shared tags, FSM encoding and frame-length helper for the commit trace streamer.
package trace_pkg;

  localparam logic [1:0] TAG_PC   = 2'd0;
  localparam logic [1:0] TAG_INST = 2'd1;
  localparam logic [1:0] TAG_REG  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EMIT_PC   = 2'd1,
    ST_EMIT_INST = 2'd2,
    ST_EMIT_REG  = 2'd3
  } state_t;

  // Words per frame: PC, INST, then every register.
  function automatic int unsigned frame_len(input int unsigned nregs);
    return 32'd2 + nregs;
  endfunction

endpackage

// File: rtl/trace_snapshot_mux.sv
// Snapshot of PC, instruction and register file taken on capture, plus the
// payload selector that picks the word for the current FSM position.
module trace_snapshot_mux
  import trace_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned NREGS  = 32,
  localparam int unsigned IDX_W  = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    capture,
  input  logic [DATA_W-1:0]       commit_pc,
  input  logic [DATA_W-1:0]       commit_inst,
  input  logic [NREGS*DATA_W-1:0] regs_flat,
  input  state_t                  state,
  input  logic [IDX_W-1:0]        idx,
  output logic [DATA_W-1:0]       data_c
);

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] inst_q;
  logic [DATA_W-1:0] regs_q [NREGS];

  // Snapshot is written only on capture so mid-frame register changes are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      inst_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (capture) begin
      pc_q   <= commit_pc;
      inst_q <= commit_inst;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_flat[i*DATA_W +: DATA_W];
    end
  end

  // Payload select; zero while idle.
  always_comb begin
    data_c = '0;
    case (state)
      ST_EMIT_PC:   data_c = pc_q;
      ST_EMIT_INST: data_c = inst_q;
      ST_EMIT_REG:  data_c = regs_q[idx];
      default:      data_c = '0;
    endcase
  end

endmodule

// File: rtl/trace_commit_streamer.sv
// Captures a committed instruction plus register file and streams it as a
// framed valid/ready word sequence, counting commits lost while busy.
module trace_commit_streamer
  import trace_pkg::*;
#(
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned NREGS     = 32,
  parameter  int unsigned PC_FILTER = 1,
  parameter  int unsigned CNT_W     = 16,
  localparam int unsigned IDX_W     = $clog2(NREGS)
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  input  logic                    trace_en,
  input  logic                    commit_valid,
  input  logic [DATA_W-1:0]       commit_pc,
  input  logic [DATA_W-1:0]       commit_inst,
  input  logic [NREGS*DATA_W-1:0] regs_flat,
  output logic                    busy,
  output logic                    tr_valid,
  input  logic                    tr_ready,
  output logic [DATA_W-1:0]       tr_data,
  output logic [1:0]              tr_tag,
  output logic [IDX_W-1:0]        tr_idx,
  output logic                    tr_last,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [CNT_W-1:0]        frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  last_pc_q;
  logic               last_pc_valid_q;
  logic [CNT_W-1:0]   drop_q;
  logic [CNT_W-1:0]   frame_q;
  logic               xfer;
  logic               frame_done;
  logic               pc_new;
  logic               capture;
  logic               drop;

  assign tr_valid   = (state_q != ST_IDLE);
  assign tr_last    = (state_q == ST_EMIT_REG) && (idx_q == LAST_IDX);
  assign tr_idx     = idx_q;
  assign xfer       = tr_valid && tr_ready;
  assign frame_done = tr_last && xfer;
  // Free on the final transfer so a new frame can follow with no gap.
  assign busy       = tr_valid && !frame_done;
  assign pc_new     = (PC_FILTER == 0) || !last_pc_valid_q || (commit_pc != last_pc_q);
  assign capture    = commit_valid && trace_en && !busy && pc_new;
  assign drop       = commit_valid && trace_en && busy;
  assign drop_cnt   = drop_q;
  assign frame_cnt  = frame_q;

  // Tag decode from FSM position.
  always_comb begin
    tr_tag = TAG_PC;
    case (state_q)
      ST_EMIT_INST: tr_tag = TAG_INST;
      ST_EMIT_REG:  tr_tag = TAG_REG;
      default:      tr_tag = TAG_PC;
    endcase
  end

  // State, register index, last-PC tracking and counters.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      last_pc_q       <= '0;
      last_pc_valid_q <= 1'b0;
      drop_q          <= '0;
      frame_q         <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        last_pc_q       <= commit_pc;
        last_pc_valid_q <= 1'b1;
      end
      if (drop && (drop_q != {CNT_W{1'b1}})) drop_q <= drop_q + CNT_W'(1);
      if (frame_done) frame_q <= frame_q + CNT_W'(1);
    end
  end

  // Next-state: advance one word per transfer; index stays 0 outside REG words.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) state_d = ST_EMIT_PC;
      end
      ST_EMIT_PC: begin
        if (xfer) state_d = ST_EMIT_INST;
      end
      ST_EMIT_INST: begin
        if (xfer) begin
          state_d = ST_EMIT_REG;
          idx_d   = '0;
        end
      end
      ST_EMIT_REG: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = capture ? ST_EMIT_PC : ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  trace_snapshot_mux #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_snap (
    .clk         (clk_in),
    .rst_n       (reset_n),
    .capture     (capture),
    .commit_pc   (commit_pc),
    .commit_inst (commit_inst),
    .regs_flat   (regs_flat),
    .state       (state_q),
    .idx         (idx_q),
    .data_c      (tr_data)
  );

endmodule

// File: tb/tb_trace_commit_streamer.sv
// Directed bench for trace_commit_streamer: table-driven frame check plus
// hand-written sequences for backpressure, drops, back-to-back and reset.
module tb_trace_commit_streamer;
  import trace_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned FL = frame_len(NR);

  typedef struct packed {
    logic        valid;
    logic [1:0]  tag;
    logic [4:0]  idx;
    logic        last;
    logic [31:0] data;
  } word_t;

  typedef struct {
    logic  ready;
    word_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, trace_en, cv, cv_nf, cv_c2, tr_ready, rdy1;
  logic [DW-1:0]     pc, inst;
  logic [NR*DW-1:0]  regs;

  logic busy, tr_valid, tr_last;
  logic [DW-1:0] tr_data;
  logic [1:0] tr_tag;
  logic [4:0] tr_idx;
  logic [15:0] drop_cnt, frame_cnt;

  logic nf_busy, nf_valid, nf_last;
  logic [DW-1:0] nf_data;
  logic [1:0] nf_tag;
  logic [4:0] nf_idx;
  logic [15:0] nf_drop, nf_frame;

  logic c2_busy, c2_valid, c2_last;
  logic [DW-1:0] c2_data;
  logic [1:0] c2_tag;
  logic [4:0] c2_idx;
  logic [1:0] c2_drop, c2_frame;

  trace_commit_streamer dut (
    .clk_in(clk), .reset_n(reset_n), .trace_en(trace_en), .commit_valid(cv),
    .commit_pc(pc), .commit_inst(inst), .regs_flat(regs), .busy(busy),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data), .tr_tag(tr_tag),
    .tr_idx(tr_idx), .tr_last(tr_last), .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
  );

  trace_commit_streamer #(.PC_FILTER(0)) dut_nf (
    .clk_in(clk), .reset_n(reset_n), .trace_en(trace_en), .commit_valid(cv_nf),
    .commit_pc(pc), .commit_inst(inst), .regs_flat(regs), .busy(nf_busy),
    .tr_valid(nf_valid), .tr_ready(rdy1), .tr_data(nf_data), .tr_tag(nf_tag),
    .tr_idx(nf_idx), .tr_last(nf_last), .drop_cnt(nf_drop), .frame_cnt(nf_frame)
  );

  trace_commit_streamer #(.CNT_W(2)) dut_c2 (
    .clk_in(clk), .reset_n(reset_n), .trace_en(trace_en), .commit_valid(cv_c2),
    .commit_pc(pc), .commit_inst(inst), .regs_flat(regs), .busy(c2_busy),
    .tr_valid(c2_valid), .tr_ready(rdy1), .tr_data(c2_data), .tr_tag(c2_tag),
    .tr_idx(c2_idx), .tr_last(c2_last), .drop_cnt(c2_drop), .frame_cnt(c2_frame)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  word_t expw [FL];
  vec_t  vec  [FL];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic word_t cur();
    return {tr_valid, tr_tag, tr_idx, tr_last, tr_data};
  endfunction

  function automatic word_t pc_word(input logic [31:0] p);
    return {1'b1, 2'd0, 5'd0, 1'b0, p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs(input logic [31:0] base, input logic [31:0] stp);
    for (int i = 0; i < NR; i++) regs[i*DW +: DW] = base + 32'(i) * stp;
  endtask

  task automatic build_exp(input logic [31:0] p, input logic [31:0] in,
                           input logic [31:0] base, input logic [31:0] stp);
    expw[0] = pc_word(p);
    expw[1] = {1'b1, 2'd1, 5'd0, 1'b0, in};
    for (int k = 2; k < FL; k++)
      expw[k] = {1'b1, 2'd2, 5'(k - 2), (k == FL - 1), base + 32'(k - 2) * stp};
  endtask

  task automatic commit(input logic [31:0] p);
    pc = p;
    cv = 1'b1;
    step();
    cv = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    tr_ready = 1'b1;
    while (tr_valid && n < 200) begin
      step();
      n++;
    end
    chk(nm, 96'(tr_valid), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] patt;
    logic        r;
    int          k;
    logic        found;

    reset_n = 1'b0; trace_en = 1'b1; cv = 1'b0; cv_nf = 1'b0; cv_c2 = 1'b0;
    tr_ready = 1'b0; rdy1 = 1'b1; pc = '0; inst = '0; regs = '0;
    step(); step();
    chk("reset_outputs", {busy, tr_valid, tr_data, tr_tag, tr_idx, tr_last, drop_cnt, frame_cnt}, 96'(0));
    reset_n = 1'b1;
    step();

    // Frame 1: table of ready inputs and expected words.
    set_regs(32'h0, 32'h11);
    inst = 32'h0810_0004;
    build_exp(32'h0040_0000, 32'h0810_0004, 32'h0, 32'h11);
    for (int i = 0; i < FL; i++) begin
      vec[i].ready = 1'b1;
      vec[i].exp   = expw[i];
    end
    tr_ready = 1'b1;
    commit(32'h0040_0000);
    for (int i = 0; i < FL; i++) begin
      tr_ready = vec[i].ready;
      chk($sformatf("f1_word%0d", i), 96'(cur()), 96'(vec[i].exp));
      step();
    end
    chk("f1_idle", {busy, tr_valid}, 96'(0));
    chk("f1_frame_cnt", 96'(frame_cnt), 96'(1));

    // Same PC is filtered: no frame, no drop.
    commit(32'h0040_0000);
    chk("filt_valid", 96'(tr_valid), 96'(0));
    step(); step();
    chk("filt_counts", {drop_cnt, frame_cnt}, {16'd0, 16'd1});

    // Backpressure frame with a mid-frame register-file change.
    set_regs(32'hA000_0000, 32'h1);
    inst = 32'h1234_5678;
    build_exp(32'h0040_0100, 32'h1234_5678, 32'hA000_0000, 32'h1);
    tr_ready = 1'b0;
    commit(32'h0040_0100);
    patt = 64'h9C93_2D4B_96A5_3C99;
    k = 0;
    for (int cyc = 0; cyc < 400 && k < FL; cyc++) begin
      if (cyc == 5) set_regs(32'hDEAD_0000, 32'h1);
      r = patt[cyc % 64];
      tr_ready = r;
      chk($sformatf("bp_word%0d", k), 96'(cur()), 96'(expw[k]));
      if (cur() !== expw[k]) break;
      if (r) k++;
      step();
    end
    chk("bp_complete", 96'(k), 96'(FL));
    drain("bp_drain");
    chk("bp_frame_cnt", 96'(frame_cnt), 96'(2));

    // Three new-PC commits while busy are dropped without touching last_pc.
    commit(32'h0050_0000);
    chk("drop_busy", 96'(busy), 96'(1));
    for (int d = 0; d < 3; d++) begin
      commit(32'h0050_0200 + 32'(d) * 32'h100);
      step();
    end
    drain("drop_drain");
    chk("drop_counts", {drop_cnt, frame_cnt}, {16'd3, 16'd3});
    set_regs(32'h5500_0000, 32'h1);
    inst = 32'h0000_0013;
    build_exp(32'h0050_0400, 32'h0000_0013, 32'h5500_0000, 32'h1);
    commit(32'h0050_0400);
    chk("drop_next_emitted", 96'(cur()), 96'(expw[0]));

    // Commit on the cycle the final word transfers: zero-gap next frame.
    for (int i = 0; i < FL; i++) begin
      chk($sformatf("b2b_word%0d", i), 96'(cur()), 96'(expw[i]));
      if (i < FL - 1) step();
    end
    chk("b2b_busy", 96'(busy), 96'(0));
    commit(32'h0090_0000);
    chk("b2b_pc", 96'(cur()), 96'(pc_word(32'h0090_0000)));
    chk("b2b_frame_cnt", 96'(frame_cnt), 96'(4));
    drain("b2b_drain");
    chk("b2b_frame_cnt2", 96'(frame_cnt), 96'(5));

    // Reset during the REG 10 word abandons the frame.
    set_regs(32'h7700_0000, 32'h1);
    commit(32'h00A0_0000);
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (tr_tag == 2'd2 && tr_idx == 5'd10) found = 1'b1;
      else step();
    end
    chk("rst_reached_reg10", 96'(found), 96'(1));
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {busy, tr_valid, tr_data, tr_tag, tr_idx, tr_last, drop_cnt, frame_cnt}, 96'(0));
    step(); step();
    reset_n = 1'b1;
    step();
    chk("rst_idle", 96'(tr_valid), 96'(0));
    set_regs(32'h8800_0000, 32'h1);
    inst = 32'hCAFE_0001;
    commit(32'h00A0_0000);
    chk("rst_restart_pc", 96'(cur()), 96'(pc_word(32'h00A0_0000)));
    step();
    chk("rst_restart_inst", 96'(cur()), 96'({1'b1, 2'd1, 5'd0, 1'b0, 32'hCAFE_0001}));
    drain("rst_drain");
    chk("rst_frame_cnt", 96'(frame_cnt), 96'(1));

    // trace_en low: commit ignored and not counted.
    trace_en = 1'b0;
    commit(32'h0B00_0000);
    chk("en_off", {tr_valid, drop_cnt}, 96'(0));
    trace_en = 1'b1;

    // PC_FILTER=0 emits a repeated PC again.
    pc = 32'h0040_0000;
    cv_nf = 1'b1; step(); cv_nf = 1'b0;
    repeat (40) step();
    chk("nf_frame1", 96'(nf_frame), 96'(1));
    cv_nf = 1'b1; step(); cv_nf = 1'b0;
    chk("nf_repeat_valid", 96'(nf_valid), 96'(1));
    repeat (40) step();
    chk("nf_frame2", 96'(nf_frame), 96'(2));

    // Two-bit drop counter saturates at 3 after five drops.
    pc = 32'h0000_0100;
    cv_c2 = 1'b1; step(); cv_c2 = 1'b0;
    for (int d = 0; d < 5; d++) begin
      pc = 32'h0000_0200 + 32'(d) * 32'h4;
      cv_c2 = 1'b1; step(); cv_c2 = 1'b0;
      step();
    end
    chk("c2_drop_sat", 96'(c2_drop), 96'(3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
